mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 4:1 select datapath among 4 requesters.

---
 rtl/mux_arb_pkg.sv | 30 +++
 rtl/mux_rr_arbiter_rr_pick.sv | 30 +++
 rtl/mux_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// The optional hold limit is enabled by defining MUX_ARB_TIMEOUT_EN.
package mux_arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      SWITCH = 2'd2
   } arb_state_e;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_REQ-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

   function automatic logic [SEL_W-1:0] to_index(input logic [NUM_REQ-1:0] vec);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (vec[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request strictly after 'last',
// wrapping, so the previous owner is always considered last.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last,
   output logic               any,
   output logic [SEL_W-1:0]   idx
);

   logic             found;
   logic [SEL_W-1:0] cand;

   // Walk offsets 1..NUM_REQ; the 2-bit add wraps naturally, offset 4 lands on last itself.
   always_comb begin
      any   = |req;
      idx   = last;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = last + SEL_W'(i);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux path with a dead gap between owners.
// Define MUX_ARB_TIMEOUT_EN to revoke an owner after MAX_HOLD grant cycles.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD   = 8,
   parameter int SWITCH_GAP = 1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [SEL_W-1:0]   sel,
   output logic               busy,
   output logic               timeout
);

   localparam int GAP_W = $clog2(SWITCH_GAP + 1);

   if (MAX_HOLD < 2 || SWITCH_GAP < 1) begin : g_bad_cfg
      $error("mux_rr_arbiter: MAX_HOLD must be >= 2 and SWITCH_GAP >= 1");
   end

   arb_state_e         state, state_next;
   logic [NUM_REQ-1:0] grant_next;
   logic [SEL_W-1:0]   sel_next, last, last_next;
   logic               busy_next;
   logic [GAP_W-1:0]   gap_cnt, gap_next;
   logic               pick_any;
   logic [SEL_W-1:0]   pick_idx;

   rr_pick u_pick (
      .req  (req),
      .last (last),
      .any  (pick_any),
      .idx  (pick_idx)
   );

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   logic [HOLD_W-1:0] hold_cnt, hold_next;
   logic              timeout_q, timeout_next;

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   // State and all outputs are registered; reset also aborts a live transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         grant   <= '0;
         sel     <= '0;
         busy    <= 1'b0;
         last    <= SEL_W'(NUM_REQ - 1);
         gap_cnt <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_cnt  <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state   <= state_next;
         grant   <= grant_next;
         sel     <= sel_next;
         busy    <= busy_next;
         last    <= last_next;
         gap_cnt <= gap_next;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_cnt  <= hold_next;
         timeout_q <= timeout_next;
`endif
      end
   end

   // Grant is only ever issued from IDLE or the final gap cycle, so the mux
   // select never changes while a grant bit is high.
   always_comb begin
      state_next = state;
      grant_next = grant;
      sel_next   = sel;
      busy_next  = busy;
      last_next  = last;
      gap_next   = gap_cnt;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_next    = hold_cnt;
      timeout_next = 1'b0;
`endif

      case (state)
         IDLE: begin
            grant_next = '0;
            busy_next  = 1'b0;
            if (pick_any) begin
               state_next = GRANT;
               grant_next = onehot(pick_idx);
               sel_next   = pick_idx;
               last_next  = pick_idx;
               busy_next  = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
               hold_next  = '0;
`endif
            end
         end

         GRANT: begin
            busy_next = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
            if (hold_cnt != HOLD_W'(MAX_HOLD)) hold_next = hold_cnt + 1'b1;
`endif
            if (!req[last]) begin
               state_next = SWITCH;
               grant_next = '0;
               gap_next   = '0;
`ifdef MUX_ARB_TIMEOUT_EN
            end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
               state_next   = SWITCH;
               grant_next   = '0;
               gap_next     = '0;
               timeout_next = 1'b1;
`endif
            end
         end

         SWITCH: begin
            grant_next = '0;
            busy_next  = 1'b1;
            if (gap_cnt == GAP_W'(SWITCH_GAP - 1)) begin
               if (pick_any) begin
                  state_next = GRANT;
                  grant_next = onehot(pick_idx);
                  sel_next   = pick_idx;
                  last_next  = pick_idx;
`ifdef MUX_ARB_TIMEOUT_EN
                  hold_next  = '0;
`endif
               end else begin
                  state_next = IDLE;
                  busy_next  = 1'b0;
               end
            end else begin
               gap_next = gap_cnt + 1'b1;
            end
         end

         default: begin
            state_next = IDLE;
            grant_next = '0;
            busy_next  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed-vector bench for mux_rr_arbiter; build-specific sequences follow
// MUX_ARB_TIMEOUT_EN.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] sel;
   logic       busy;
   logic       timeout;

   int vecCount;
   int missCount;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
      logic       timeout;
      logic       chkSel;
   } vec_t;

   vec_t vecs[20];

   mux_rr_arbiter #(.MAX_HOLD(8), .SWITCH_GAP(1)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .grant   (grant),
      .sel     (sel),
      .busy    (busy),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive inputs mid-cycle, then let one rising edge register the response.
   task automatic applyStimulus(input logic r, input logic [3:0] q);
      @(negedge clk);
      rst = r;
      req = q;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] es,
                              input logic eb, input logic et, input logic chkSel);
      vecCount++;
      if (grant !== eg || busy !== eb || timeout !== et || (chkSel && sel !== es)) begin
         missCount++;
         $display("[TB] FAIL %s: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
                  name, grant, sel, busy, timeout, eg, es, eb, et);
      end
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      rst = 1'b1;
      req = 4'h0;

      vecs = '{
         '{1'b1, 4'hF,    4'b0000, 2'd0, 1'b0, 1'b0, 1'b1},
         '{1'b1, 4'hF,    4'b0000, 2'd0, 1'b0, 1'b0, 1'b1},
         '{1'b0, 4'hF,    4'b0001, 2'd0, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'h0,    4'b0000, 2'd0, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'h0,    4'b0000, 2'd0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'h0,    4'b0000, 2'd2, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'h0,    4'b0000, 2'd0, 1'b0, 1'b0, 1'b0},
         '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1},
         '{1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1},
         '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'h0,    4'b0000, 2'd3, 1'b1, 1'b0, 1'b1},
         '{1'b0, 4'h0,    4'b0000, 2'd0, 1'b0, 1'b0, 1'b0}
      };

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].req);
         checkOutput($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel,
                     vecs[i].busy, vecs[i].timeout, vecs[i].chkSel);
      end

      applyStimulus(1'b1, 4'h0);
      checkOutput("reset_again", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);

`ifdef MUX_ARB_TIMEOUT_EN
      // Full request load: each owner is revoked after 8 grant cycles, then one gap.
      begin
         logic [1:0] owners [5];
         logic [3:0] oh;
         owners = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
         for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << owners[k];
            for (int c = 0; c < 8; c++) begin
               applyStimulus(1'b0, 4'hF);
               checkOutput($sformatf("rot_o%0d_c%0d", k, c), oh, owners[k], 1'b1, 1'b0, 1'b1);
            end
            applyStimulus(1'b0, 4'hF);
            checkOutput($sformatf("rot_gap%0d", k), 4'b0000, owners[k], 1'b1, 1'b1, 1'b1);
         end
      end

      applyStimulus(1'b1, 4'h0);
      checkOutput("coin_reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, 4'b0001);
         checkOutput($sformatf("coin_grant%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
      end
      applyStimulus(1'b0, 4'b0000);
      checkOutput("coin_switch", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0000);
      checkOutput("coin_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
`else
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b0, 4'b1001);
         checkOutput($sformatf("hold%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
      end
      applyStimulus(1'b0, 4'b0000);
      checkOutput("hold_switch", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0000);
      checkOutput("hold_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
